bus_term_fifo: RTL and testbench
================================

// Module: bus_term_fifo
// PURPOSE
//  Per-terminal source FIFO sitting directly upstream of the multi-driver bus DUT.
//  The agent/driver side writes packets; the bus side sees pndng/D_pop and consumes with pop.
//  One instance per [bit][drvr] terminal; its outputs drive that terminal's pndng and D_pop inputs of the bus.
//  Provides overflow policy, status flags and error counters for the scoreboard.
// PARAMETERS
//  pckg_sz     16  packet width in bits (must be >= 1)
//  depth       8   FIFO entries; power of two, >= 2
//  AF_LVL      6   almost_full asserted when count >= AF_LVL (1..depth)
//  OVF_POLICY  0   0: drop incoming on full; 1: overwrite oldest on full
//  CNT_W       8   width of ovf_cnt / udf_cnt
// PORTS
//  clk          in   1                     clock, all state on rising edge
//  reset        in   1                     asynchronous, active-high
//  in_push      in   1                     agent write strobe
//  in_data      in   pckg_sz               agent write data
//  pndng        out  1                     FIFO non-empty (to bus pndng)
//  D_pop        out  pckg_sz               head entry (to bus D_pop); 0 when empty
//  pop          in   1                     bus consumes head this cycle
//  full         out  1                     count == depth
//  almost_full  out  1                     count >= AF_LVL
//  count        out  $clog2(depth)+1       current occupancy
//  ovf_cnt      out  CNT_W                 overflow events, saturating
//  udf_cnt      out  CNT_W                 pop-while-empty events, saturating
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert by the system): rd/wr pointers, count,
//    ovf_cnt, udf_cnt = 0; pndng=0, full=0, almost_full=0, D_pop=0. Storage array not reset.
//  - Reset mid-operation discards all queued packets immediately; no pop/push honoured while reset=1.
//  - First-word-fall-through: D_pop = mem[rd_ptr] whenever pndng=1, else 0 (combinational from flops).
//  - Write latency: in_push accepted at edge N -> pndng=1 and D_pop valid right after edge N.
//  - pop honoured only when pndng=1: rd_ptr advances at the edge, next head appears after it.
//  - pop with pndng=0: no state change except udf_cnt+1 (saturating at 2^CNT_W-1).
//  - Pointers are $clog2(depth) bits and wrap naturally depth-1 -> 0.
//  - Simultaneous in_push & pop, non-empty, not full: both honoured, count unchanged.
//  - Simultaneous in_push & pop, empty: push accepted, pop ignored and counted in udf_cnt.
//  - Simultaneous in_push & pop, full: pop frees head, push accepted, count stays depth,
//    no overflow counted.
//  - in_push while full, no pop:
//      OVF_POLICY=0: in_data dropped, state unchanged, ovf_cnt+1.
//      OVF_POLICY=1: oldest entry overwritten (write at wr_ptr, both pointers advance),
//                    count stays depth, ovf_cnt+1.
//  - full/almost_full/pndng/count are registered-state-derived; all reflect state after each edge.
//  - Counters saturate; they never wrap. Cleared only by reset.
// TESTING
//  1. Reset then push 0xA5A5 at edge 1 -> pndng=1, D_pop=0xA5A5, count=1 after edge 1;
//     pop at edge 2 -> pndng=0, D_pop=0.
//  2. Push 8 packets 1..8 (depth=8) -> full=1, almost_full from 6th push;
//     pop 8 times -> D_pop sequence 1..8, pointer wrap exercised.
//  3. Full, OVF_POLICY=0, push 0x0099 -> dropped, ovf_cnt=1, pop order still 1..8;
//     OVF_POLICY=1 -> pop order 2..8,0x0099.
//  4. Full, push 9 & pop same cycle -> count=8, ovf_cnt=0, head becomes 2, tail 9.
//  5. Empty, push 0x1234 & pop same cycle -> count=1, D_pop=0x1234, udf_cnt=1;
//     CNT_W=2 with 5 empty pops -> udf_cnt=3.
//  6. Load 5 packets, assert reset mid-cycle -> pndng, count, full drop to 0 immediately;
//     after release first push reads back correctly.

Source files
------------

// File: rtl/bus_term_fifo.sv
// Per-terminal first-word-fall-through source FIFO feeding one bus terminal's pndng/D_pop,
// with a selectable overflow policy and saturating overflow/underflow event counters.
module bus_term_fifo #(
  parameter int pckg_sz    = 16,
  parameter int depth      = 8,
  parameter int AF_LVL     = 6,
  parameter int OVF_POLICY = 0,
  parameter int CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_push,
  input  logic [pckg_sz-1:0]       in_data,
  output logic                     pndng,
  output logic [pckg_sz-1:0]       D_pop,
  input  logic                     pop,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(depth):0]   count,
  output logic [CNT_W-1:0]         ovf_cnt,
  output logic [CNT_W-1:0]         udf_cnt
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] DEPTH_C = depth[AW:0];
  localparam logic [AW:0] AF_C    = AF_LVL[AW:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [pckg_sz-1:0] mem [depth];
  logic [AW-1:0]      rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]        count_reg, count_next;
  logic [CNT_W-1:0]   ovf_reg, udf_reg;
  logic               empty, is_full, wr_en, rd_en, ovf_evt, udf_evt;

  // A full FIFO still takes a push when the same cycle's pop frees a slot; otherwise
  // the policy decides between dropping the new word and evicting the oldest one.
  always_comb begin
    empty      = (count_reg == '0);
    is_full    = (count_reg == DEPTH_C);
    udf_evt    = pop & empty;
    ovf_evt    = in_push & is_full & ~pop;
    wr_en      = in_push & (~is_full | pop | (OVF_POLICY != 0));
    rd_en      = (pop & ~empty) | (ovf_evt & (OVF_POLICY != 0));
    count_next = count_reg + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= '0;
      udf_reg    <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      if (ovf_evt && ovf_reg != CNT_MAX) ovf_reg <= ovf_reg + CNT_W'(1);
      if (udf_evt && udf_reg != CNT_MAX) udf_reg <= udf_reg + CNT_W'(1);
    end
  end

  // Storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_ptr_reg] <= in_data;
  end

  assign pndng       = ~empty;
  assign D_pop       = empty ? '0 : mem[rd_ptr_reg];
  assign full        = is_full;
  assign almost_full = (count_reg >= AF_C);
  assign count       = count_reg;
  assign ovf_cnt     = ovf_reg;
  assign udf_cnt     = udf_reg;

endmodule

// File: tb/tb_bus_term_fifo.sv
// Scoreboard bench: two FIFOs (drop policy / overwrite policy with 2-bit counters) share
// stimulus; a packet-queue reference model predicts every post-edge state.
module tb_bus_term_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_push = 1'b0;
  logic [15:0] in_data = '0;
  logic        pop = 1'b0;

  logic        pndng0, full0, af0, pndng1, full1, af1;
  logic [15:0] dpop0, dpop1;
  logic [3:0]  count0, count1;
  logic [7:0]  ovf0, udf0;
  logic [1:0]  ovf1, udf1;

  bus_term_fifo #(.pckg_sz(16), .depth(8), .AF_LVL(6), .OVF_POLICY(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .in_push(in_push), .in_data(in_data),
    .pndng(pndng0), .D_pop(dpop0), .pop(pop), .full(full0), .almost_full(af0),
    .count(count0), .ovf_cnt(ovf0), .udf_cnt(udf0));

  bus_term_fifo #(.pckg_sz(16), .depth(8), .AF_LVL(6), .OVF_POLICY(1), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .in_push(in_push), .in_data(in_data),
    .pndng(pndng1), .D_pop(dpop1), .pop(pop), .full(full1), .almost_full(af1),
    .count(count1), .ovf_cnt(ovf1), .udf_cnt(udf1));

  always #5 clk = ~clk;

  typedef logic [15:0] pq_t[$];
  typedef struct {
    int          cyc;
    int          d;
    logic        pu;
    logic        po;
    logic [15:0] dt;
    logic        pndng;
    logic [15:0] dpop;
    int          count;
    logic        full;
    logic        af;
    int          ovf;
    int          udf;
  } exp_t;

  exp_t exp_q[$];
  pq_t  mq0, mq1;
  int   mov[2];
  int   mud[2];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int d, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, d, cyc, got, want);
    end
  endtask

  // Reference: a plain packet queue; policy 1 evicts the oldest packet on overflow.
  task automatic model_step(input int d, input logic r, input logic pu,
                            input logic [15:0] dt, input logic po);
    pq_t  q;
    int   ov, ud, mx;
    bit   was_empty, was_full;
    exp_t e;
    if (d == 0) q = mq0; else q = mq1;
    ov = mov[d];
    ud = mud[d];
    mx = (d == 0) ? 255 : 3;
    if (r) begin
      q.delete();
      ov = 0;
      ud = 0;
    end else begin
      was_empty = (q.size() == 0);
      was_full  = (q.size() == 8);
      if (po && was_empty && ud < mx) ud++;
      if (po && !was_empty) void'(q.pop_front());
      if (pu) begin
        if (was_full && !po) begin
          if (ov < mx) ov++;
          if (d == 1) begin
            void'(q.pop_front());
            q.push_back(dt);
          end
        end else begin
          q.push_back(dt);
        end
      end
    end
    if (d == 0) mq0 = q; else mq1 = q;
    mov[d] = ov;
    mud[d] = ud;
    e.cyc   = cyc + 1;
    e.d     = d;
    e.pu    = pu;
    e.po    = po;
    e.dt    = dt;
    e.pndng = (q.size() != 0);
    e.dpop  = (q.size() != 0) ? q[0] : 16'h0;
    e.count = q.size();
    e.full  = (q.size() == 8);
    e.af    = (q.size() >= 6);
    e.ovf   = ov;
    e.udf   = ud;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic r, input logic pu, input logic [15:0] dt, input logic po);
    @(posedge clk);
    #1;
    reset   = r;
    in_push = pu;
    in_data = dt;
    pop     = po;
    model_step(0, r, pu, dt, po);
    model_step(1, r, pu, dt, po);
  endtask

  // Reset asserted between edges must clear status at once, not at the next edge.
  task automatic mid_reset();
    @(posedge clk);
    #1;
    in_push = 1'b0;
    pop     = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_pndng", 0, int'(pndng0), 0);
    chk("rst_count", 0, int'(count0), 0);
    chk("rst_full",  0, int'(full0), 0);
    chk("rst_dpop",  0, int'(dpop0), 0);
    chk("rst_pndng", 1, int'(pndng1), 0);
    chk("rst_count", 1, int'(count1), 0);
    mq0.delete();
    mq1.delete();
    mov = '{0, 0};
    mud = '{0, 0};
  endtask

  exp_t me;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      logic        gp, gf, ga;
      logic [15:0] gd;
      int          gc, go, gu;
      me = exp_q.pop_front();
      if (me.d == 0) begin
        gp = pndng0; gd = dpop0; gc = int'(count0); gf = full0; ga = af0;
        go = int'(ovf0); gu = int'(udf0);
      end else begin
        gp = pndng1; gd = dpop1; gc = int'(count1); gf = full1; ga = af1;
        go = int'(ovf1); gu = int'(udf1);
      end
      $display("cyc %0d dut%0d push=%0b data=%04h pop=%0b -> pndng=%0b head=%04h count=%0d ovf=%0d udf=%0d",
               me.cyc, me.d, me.pu, me.dt, me.po, gp, gd, gc, go, gu);
      chk("pndng", me.d, int'(gp), int'(me.pndng));
      chk("D_pop", me.d, int'(gd), int'(me.dpop));
      chk("count", me.d, gc, me.count);
      chk("full",  me.d, int'(gf), int'(me.full));
      chk("almost_full", me.d, int'(ga), int'(me.af));
      chk("ovf_cnt", me.d, go, me.ovf);
      chk("udf_cnt", me.d, gu, me.udf);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    mov = '{0, 0};
    mud = '{0, 0};
    cycle(1, 0, 16'h0, 0);
    cycle(1, 0, 16'h0, 0);
    // single packet in and out
    cycle(0, 1, 16'hA5A5, 0);
    cycle(0, 0, 16'h0, 1);
    cycle(0, 0, 16'h0, 0);
    // fill to full, drain with pointer wrap
    for (int i = 1; i <= 8; i++) cycle(0, 1, 16'(i), 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 16'h0, 1);
    // overflow: drop vs overwrite
    for (int i = 1; i <= 8; i++) cycle(0, 1, 16'(i), 0);
    cycle(0, 1, 16'h0099, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 16'h0, 1);
    // push and pop together while full
    for (int i = 1; i <= 8; i++) cycle(0, 1, 16'(i), 0);
    cycle(0, 1, 16'h0009, 1);
    for (int i = 0; i < 8; i++) cycle(0, 0, 16'h0, 1);
    // push and pop together while empty, then underflow saturation
    cycle(0, 1, 16'h1234, 1);
    cycle(0, 0, 16'h0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 16'h0, 1);
    // reset with packets queued
    for (int i = 0; i < 5; i++) cycle(0, 1, 16'(16'h0100 + i), 0);
    mid_reset();
    cycle(1, 0, 16'h0, 0);
    cycle(0, 1, 16'hBEEF, 0);
    cycle(0, 0, 16'h0, 1);
    // randomized traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 400; i++) begin
      int pp;
      pp = ((i / 50) % 2 == 0) ? 70 : 30;
      cycle(0, $urandom_range(0, 99) < pp, 16'($urandom), $urandom_range(0, 99) < (100 - pp));
    end
    cycle(0, 0, 16'h0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("drain", 0, exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
